timer_pwm_compare: RTL and testbench
====================================

Name: timer_pwm_compare

Overview:
- Multi-channel compare/PWM stage directly downstream of the SOC timer.
- Consumes the timer's running count, its count-advance tick and its wrap pulse; produces per-channel PWM outputs and a level interrupt on compare match.
- Attached as an Avalon RW slave on the peripheral bus, same decode scheme as the timer.
- Compare values are double-buffered so that new duty cycles take effect only at a timer wrap.

Parameters:
- ADDR_SEL_BITS, 0, number of upper address bits consumed by the bus decoder.
- ADDR_BLOCK, 0, block index on the peripheral bus (decoder use only).
- CHANNELS, 4, number of compare/PWM channels, legal 1..8.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_AV_SlaveSel  in  1  slave select from bus decoder.
- i_AV_RegAddr  in  30-ADDR_SEL_BITS  word register address.
- i_AV_ByteEn  in  4  write byte enables.
- i_AV_Read  in  1  read strobe.
- i_AV_Write  in  1  write strobe.
- o_AV_ReadData  out  32  read data, valid the cycle after i_AV_Read.
- i_AV_WriteData  in  32  write data.
- o_AV_WaitRequest  out  1  tied 0.
- i_TimerValue  in  32  timer count.
- i_TimerTick  in  1  one-cycle pulse: the timer count advances this cycle.
- i_TimerWrap  in  1  one-cycle pulse: the count returns to 0 this cycle.
- o_Pwm  out  CHANNELS  registered PWM outputs.
- o_Irq  out  1  registered level interrupt.

Behaviour:
- Reset: all registers 0; o_Pwm=0, o_Irq=0, o_AV_ReadData=0.
- Register map (word addresses; unmapped reads return 0, unmapped writes are ignored):
  - 0 CNTRL: bit0 Enable; [15:8] Polarity per channel; [23:16] IrqEn per channel. Read/write, byte-enabled.
  - 1 STATUS: [7:0] match pending. Write-1-to-clear (byte 0 only). Bits 31:9 read 0.
  - 2+ch SHADOW: 32-bit compare shadow for channel ch. Read/write, byte-enabled.
  - 10+ch ACTIVE: active compare for channel ch. Read-only.
- Bits for channels >= CHANNELS are not stored and read 0.
- Reads: 1-cycle latency, registered. o_AV_ReadData is 0 on any cycle without a selected read.
- Shadow load: ACTIVE[ch] <= SHADOW[ch] for all channels on a cycle with i_TimerWrap=1 and Enable=1.
  - A SHADOW write in the same cycle as a wrap: ACTIVE takes the old SHADOW value; the new value loads at the next wrap.
  - While Enable=0, ACTIVE tracks SHADOW every cycle, so the first period after enabling uses the programmed values.
- PWM: each cycle o_Pwm[ch] <= Enable & ((i_TimerValue < ACTIVE[ch]) ^ Polarity[ch]).
  - Comparison is unsigned, 32-bit.
  - Output lags i_TimerValue by 1 cycle.
  - ACTIVE=0 gives constant 0 (or 1 if inverted). ACTIVE greater than the trigger value gives constant 1.
  - Enable=0 forces o_Pwm=0 regardless of Polarity.
- Match: pending[ch] sets on a cycle with Enable & i_TimerTick & (i_TimerValue == ACTIVE[ch]).
  - A set and a W1C of the same bit in the same cycle: set wins, bit stays 1.
  - Pending is sticky; it is not cleared by Enable=0.
- IRQ: o_Irq <= |(pending & IrqEn), registered, so it follows pending by 1 cycle.
- Clearing Enable does not clear SHADOW, ACTIVE or CNTRL fields.
- Reset asserted mid-operation clears everything immediately; the block restarts with Enable=0.

Optional Feature:
- Macro: TIMER_PWM_CAPTURE_EN.
- Defined:
  - Adds input i_Capture (1 bit, asynchronous), passed through a 2-FF synchronizer.
  - A synchronized rising edge loads the CAPTURE register (address 18, read-only) with i_TimerValue and sets STATUS bit 8.
  - STATUS bit 8 is W1C via byte 1; on a simultaneous set and clear, set wins.
  - CNTRL bit 24 CapIrqEn ORs (bit8 & CapIrqEn) into o_Irq.
  - Capture-edge to CAPTURE-valid latency: 3 cycles.
- Not defined: no i_Capture port; address 18, STATUS bit 8 and CNTRL bit 24 read 0, and writes to them are ignored.

Test Plan:
- Reset then read all registers -> all 0; o_Pwm=0; o_Irq=0; o_AV_WaitRequest=0 throughout.
- Write SHADOW0=5, CNTRL=0x1, drive the timer 0..9 with a wrap at 9 -> o_Pwm[0]=1 for values 0..4, 0 for 5..9, each 1 cycle late; with Polarity0=1 -> inverted.
- Write SHADOW0=8 mid-period while ACTIVE0=5 -> ACTIVE0 reads 5 until the wrap pulse, 8 after it; a write coincident with the wrap -> the old shadow is loaded.
- IrqEn0=1, SHADOW0=3, tick at value 3 -> STATUS=0x01, o_Irq=1 one cycle later; W1C 0x01 -> o_Irq=0; a W1C coincident with a new match -> bit stays 1.
- Assert i_Reset while Enable=1 and the PWM is high -> o_Pwm, o_Irq and all registers go to 0 immediately (asynchronously).
- With TIMER_PWM_CAPTURE_EN, pulse i_Capture while i_TimerValue=0x1234 -> CAPTURE=0x1234 (within 3 cycles of the rising edge), STATUS bit 8 set, o_Irq=1 if CapIrqEn=1; without the macro, address 18 reads 0.

Source files
------------

// File: rtl/timer_pwm_compare_if.sv
// Avalon RW slave bundle for the timer compare/PWM block; the slave never stalls, so wait-request stays low.
// Read data follows a selected read by one cycle; there is no backpressure path.
interface timer_pwm_compare_if #(
    parameter int ADDR_W = 30
);
    logic              AV_SlaveSel;
    logic [ADDR_W-1:0] AV_RegAddr;
    logic [3:0]        AV_ByteEn;
    logic              AV_Read;
    logic              AV_Write;
    logic [31:0]       AV_ReadData;
    logic [31:0]       AV_WriteData;
    logic              AV_WaitRequest;

    modport master (
        output AV_SlaveSel, AV_RegAddr, AV_ByteEn, AV_Read, AV_Write, AV_WriteData,
        input  AV_ReadData, AV_WaitRequest
    );

    modport slave (
        input  AV_SlaveSel, AV_RegAddr, AV_ByteEn, AV_Read, AV_Write, AV_WriteData,
        output AV_ReadData, AV_WaitRequest
    );
endinterface

// File: rtl/timer_pwm_compare.sv
// Double-buffered compare/PWM channels on the SOC timer count; PWM/IRQ/read data registered (1 cycle), no backpressure.
// Defining TIMER_PWM_CAPTURE_EN adds a synchronized capture input, the CAPTURE register and STATUS bit 8.
module timer_pwm_compare #(
    parameter int ADDR_SEL_BITS = 0,
    parameter int ADDR_BLOCK    = 0,
    parameter int CHANNELS      = 4
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    timer_pwm_compare_if.slave  io_AV,
    input  logic [31:0]         i_TimerValue,
    input  logic                i_TimerTick,
    input  logic                i_TimerWrap,
`ifdef TIMER_PWM_CAPTURE_EN
    input  logic                i_Capture,
`endif
    output logic [CHANNELS-1:0] o_Pwm,
    output logic                o_Irq
);

    localparam int AW = 30 - ADDR_SEL_BITS;

    if (ADDR_BLOCK < 0 || CHANNELS < 1 || CHANNELS > 8) begin : g_param_check
        $error("timer_pwm_compare: illegal ADDR_BLOCK or CHANNELS");
    end

    logic                r_enable;
    logic [CHANNELS-1:0] r_pol;
    logic [CHANNELS-1:0] r_irqen;
    logic [CHANNELS-1:0] r_pending;
    logic [31:0]         r_shadow [CHANNELS];
    logic [31:0]         r_active [CHANNELS];
    logic [CHANNELS-1:0] r_pwm;
    logic                r_irq;
    logic [31:0]         r_read_data;

    logic                w_wr;
    logic                w_rd;
    logic [AW-1:0]       w_addr;
    logic [31:0]         w_wdat;
    logic [3:0]          w_be;
    logic                w_cntrl_wr;
    logic                w_status_wr;
    logic [CHANNELS-1:0] w_shadow_wr;
    logic [CHANNELS-1:0] w_match;
    logic [CHANNELS-1:0] w_pwm_next;
    logic [CHANNELS-1:0] w_pend_clr;
    logic [31:0]         w_rd_data;
    logic                w_irq_next;

    assign w_wr        = io_AV.AV_SlaveSel & io_AV.AV_Write;
    assign w_rd        = io_AV.AV_SlaveSel & io_AV.AV_Read;
    assign w_addr      = io_AV.AV_RegAddr;
    assign w_wdat      = io_AV.AV_WriteData;
    assign w_be        = io_AV.AV_ByteEn;
    assign w_cntrl_wr  = w_wr && (w_addr == AW'(0));
    assign w_status_wr = w_wr && (w_addr == AW'(1));
    assign w_pend_clr  = (w_status_wr && w_be[0]) ? w_wdat[CHANNELS-1:0] : '0;

`ifdef TIMER_PWM_CAPTURE_EN
    logic        r_cap_meta;
    logic        r_cap_sync;
    logic        r_cap_prev;
    logic [31:0] r_capture;
    logic        r_cap_pend;
    logic        r_cap_irq_en;
    logic        w_cap_rise;
    logic        w_cap_clr;

    assign w_cap_rise = r_cap_sync & ~r_cap_prev;
    assign w_cap_clr  = w_status_wr & w_be[1] & w_wdat[8];

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_cap_meta   <= 1'b0;
            r_cap_sync   <= 1'b0;
            r_cap_prev   <= 1'b0;
            r_capture    <= '0;
            r_cap_pend   <= 1'b0;
            r_cap_irq_en <= 1'b0;
        end else begin
            r_cap_meta <= i_Capture;
            r_cap_sync <= r_cap_meta;
            r_cap_prev <= r_cap_sync;
            if (w_cap_rise) begin
                r_capture <= i_TimerValue;
            end
            // a new capture edge beats a simultaneous clear
            r_cap_pend <= (r_cap_pend & ~w_cap_clr) | w_cap_rise;
            if (w_cntrl_wr && w_be[3]) begin
                r_cap_irq_en <= w_wdat[24];
            end
        end
    end

    assign w_irq_next = (|(r_pending & r_irqen)) | (r_cap_pend & r_cap_irq_en);
`else
    assign w_irq_next = |(r_pending & r_irqen);
`endif

    always_comb begin
        w_match     = '0;
        w_pwm_next  = '0;
        w_shadow_wr = '0;
        w_rd_data   = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_match[ch]     = r_enable & i_TimerTick & (i_TimerValue == r_active[ch]);
            w_pwm_next[ch]  = r_enable & ((i_TimerValue < r_active[ch]) ^ r_pol[ch]);
            w_shadow_wr[ch] = w_wr && (w_addr == AW'(ch + 2));
            if (w_addr == AW'(ch + 2)) begin
                w_rd_data = r_shadow[ch];
            end
            if (w_addr == AW'(ch + 10)) begin
                w_rd_data = r_active[ch];
            end
        end
        if (w_addr == AW'(0)) begin
            w_rd_data[0]             = r_enable;
            w_rd_data[8 +: CHANNELS] = r_pol;
            w_rd_data[16 +: CHANNELS] = r_irqen;
`ifdef TIMER_PWM_CAPTURE_EN
            w_rd_data[24]            = r_cap_irq_en;
`endif
        end
        if (w_addr == AW'(1)) begin
            w_rd_data[CHANNELS-1:0] = r_pending;
`ifdef TIMER_PWM_CAPTURE_EN
            w_rd_data[8]            = r_cap_pend;
`endif
        end
`ifdef TIMER_PWM_CAPTURE_EN
        if (w_addr == AW'(18)) begin
            w_rd_data = r_capture;
        end
`endif
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_enable    <= 1'b0;
            r_pol       <= '0;
            r_irqen     <= '0;
            r_pending   <= '0;
            r_pwm       <= '0;
            r_irq       <= 1'b0;
            r_read_data <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_shadow[ch] <= '0;
                r_active[ch] <= '0;
            end
        end else begin
            r_read_data <= w_rd ? w_rd_data : '0;
            r_pwm       <= w_pwm_next;
            r_irq       <= w_irq_next;
            // a match beats a simultaneous write-1-to-clear
            r_pending   <= (r_pending & ~w_pend_clr) | w_match;
            if (w_cntrl_wr) begin
                if (w_be[0]) r_enable <= w_wdat[0];
                if (w_be[1]) r_pol    <= w_wdat[8 +: CHANNELS];
                if (w_be[2]) r_irqen  <= w_wdat[16 +: CHANNELS];
            end
            for (int ch = 0; ch < CHANNELS; ch++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_shadow_wr[ch] && w_be[b]) begin
                        r_shadow[ch][8*b +: 8] <= w_wdat[8*b +: 8];
                    end
                end
                // disabled: track shadow so the first enabled period uses it
                if (!r_enable || i_TimerWrap) begin
                    r_active[ch] <= r_shadow[ch];
                end
            end
        end
    end

    assign o_Pwm                = r_pwm;
    assign o_Irq                = r_irq;
    assign io_AV.AV_ReadData    = r_read_data;
    assign io_AV.AV_WaitRequest = 1'b0;

endmodule

// File: tb/tb_timer_pwm_compare.sv
// Randomized and directed stimulus for timer_pwm_compare, checked every cycle against a register-level reference model.
module tb_timer_pwm_compare;

    localparam int NCH = 4;
    localparam int AW  = 30;
    localparam logic [7:0] CHMASK = 8'((1 << NCH) - 1);

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    tv;
    logic           tick;
    logic           wrap;
    logic [NCH-1:0] pwm;
    logic           irq;
    logic           cap_in;

    always #5 clk = ~clk;

    timer_pwm_compare_if #(.ADDR_W(AW)) av ();

    timer_pwm_compare #(.ADDR_SEL_BITS(0), .ADDR_BLOCK(0), .CHANNELS(NCH)) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .io_AV        (av.slave),
        .i_TimerValue (tv),
        .i_TimerTick  (tick),
        .i_TimerWrap  (wrap),
`ifdef TIMER_PWM_CAPTURE_EN
        .i_Capture    (cap_in),
`endif
        .o_Pwm        (pwm),
        .o_Irq        (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic           m_en;
    logic [7:0]     m_pol, m_irqen, m_pend;
    logic [31:0]    m_sh [NCH];
    logic [31:0]    m_act [NCH];
    logic [NCH-1:0] m_pwm;
    logic           m_irq;
    logic [31:0]    m_rd;
    logic           m_capirqen, m_cappend;
    logic [31:0]    m_cap;
    logic           h1, h2, h3;

    int tper = 10;
    int tcnt = 0;

    task automatic model_reset();
        m_en = 0; m_pol = 0; m_irqen = 0; m_pend = 0;
        m_pwm = 0; m_irq = 0; m_rd = 0;
        m_capirqen = 0; m_cappend = 0; m_cap = 0;
        h1 = 0; h2 = 0; h3 = 0;
        for (int c = 0; c < NCH; c++) begin
            m_sh[c] = 0;
            m_act[c] = 0;
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        logic [31:0] r;
        r = 0;
`ifdef TIMER_PWM_CAPTURE_EN
        if (a == 0) r = {7'b0, m_capirqen, m_irqen, m_pol, 7'b0, m_en};
        else if (a == 1) r = {23'b0, m_cappend, m_pend};
        else if (a == 18) r = m_cap;
`else
        if (a == 0) r = {8'b0, m_irqen, m_pol, 7'b0, m_en};
        else if (a == 1) r = {24'b0, m_pend};
`endif
        else if (a >= 2 && a < 2 + NCH) r = m_sh[a-2];
        else if (a >= 10 && a < 10 + NCH) r = m_act[a-10];
        return r;
    endfunction

    // advance the model by one clock edge using the inputs currently driven
    task automatic model_step();
        int a;
        logic wr, st_wr, rise;
        logic [7:0] set, clr;
        a     = int'(av.AV_RegAddr);
        wr    = av.AV_SlaveSel & av.AV_Write;
        st_wr = wr && a == 1;
        m_rd  = (av.AV_SlaveSel & av.AV_Read) ? m_read(a) : 32'h0;
`ifdef TIMER_PWM_CAPTURE_EN
        m_irq = (|(m_pend & m_irqen)) | (m_cappend & m_capirqen);
`else
        m_irq = |(m_pend & m_irqen);
`endif
        set = 0;
        for (int c = 0; c < NCH; c++) begin
            m_pwm[c] = m_en & ((tv < m_act[c]) ^ m_pol[c]);
            set[c]   = m_en & tick & (tv == m_act[c]);
        end
        clr    = (st_wr && av.AV_ByteEn[0]) ? av.AV_WriteData[7:0] & CHMASK : 8'h0;
        m_pend = (m_pend & ~clr) | set;
        rise = h2 & ~h3;
`ifdef TIMER_PWM_CAPTURE_EN
        if (rise) m_cap = tv;
        m_cappend = (m_cappend & ~(st_wr & av.AV_ByteEn[1] & av.AV_WriteData[8])) | rise;
        if (wr && a == 0 && av.AV_ByteEn[3]) m_capirqen = av.AV_WriteData[24];
`endif
        h3 = h2; h2 = h1; h1 = cap_in;
        for (int c = 0; c < NCH; c++)
            if (!m_en || wrap) m_act[c] = m_sh[c];
        if (wr && a == 0) begin
            if (av.AV_ByteEn[0]) m_en    = av.AV_WriteData[0];
            if (av.AV_ByteEn[1]) m_pol   = av.AV_WriteData[15:8] & CHMASK;
            if (av.AV_ByteEn[2]) m_irqen = av.AV_WriteData[23:16] & CHMASK;
        end
        if (wr && a >= 2 && a < 2 + NCH)
            m_sh[a-2] = merge(m_sh[a-2], av.AV_WriteData, av.AV_ByteEn);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("pwm", 32'(pwm), 32'(m_pwm));
        check("irq", 32'(irq), 32'(m_irq));
        check("rdata", av.AV_ReadData, m_rd);
        check("waitreq", 32'(av.AV_WaitRequest), 32'h0);
    endtask

    task automatic bus_idle();
        av.AV_SlaveSel = 0; av.AV_Read = 0; av.AV_Write = 0;
        av.AV_RegAddr = '0; av.AV_ByteEn = 0; av.AV_WriteData = 0;
    endtask

    task automatic bus_set(input logic r, input logic w, input int a, input logic [31:0] d, input logic [3:0] be);
        av.AV_SlaveSel = 1; av.AV_Read = r; av.AV_Write = w;
        av.AV_RegAddr = AW'(a); av.AV_ByteEn = be; av.AV_WriteData = d;
    endtask

    task automatic tstep();
        tv   = 32'(tcnt);
        tick = 1;
        wrap = (tcnt == tper - 1);
        tcnt = (tcnt == tper - 1) ? 0 : tcnt + 1;
    endtask

    task automatic thold();
        tick = 0;
        wrap = 0;
    endtask

    task automatic op_wr(input int a, input logic [31:0] d, input logic [3:0] be);
        bus_set(0, 1, a, d, be); thold(); cycle(); bus_idle();
    endtask

    task automatic op_rd(input int a);
        bus_set(1, 0, a, 0, 0); thold(); cycle(); bus_idle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tstep(); cycle();
        end
        thold();
    endtask

    task automatic run_to(input int v);
        for (int k = 0; k < 64 && tcnt != v; k++) begin
            tstep(); cycle();
        end
        thold();
    endtask

    task automatic read_all();
        for (int a = 0; a < 20; a++) op_rd(a);
    endtask

    initial begin
        rst = 0; tv = 0; tick = 0; wrap = 0; cap_in = 0;
        bus_idle();
        model_reset();
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pwm", 32'(pwm), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_rdata", av.AV_ReadData, 32'h0);
        rst = 0;
        read_all();

        // basic PWM, then inverted polarity
        tper = 10; tcnt = 0;
        op_wr(2, 32'd5, 4'hF);
        op_wr(0, 32'h1, 4'hF);
        run(22);
        op_wr(0, 32'h101, 4'hF);
        run(22);
        op_wr(0, 32'h1, 4'hF);

        // shadow update mid-period, then coincident with the wrap
        run_to(3);
        op_wr(2, 32'd8, 4'hF);
        for (int i = 0; i < 12; i++) begin
            bus_set(1, 0, 10, 0, 0); tstep(); cycle();
        end
        bus_idle();
        run_to(tper - 1);
        bus_set(0, 1, 2, 32'd20, 4'hF); tstep(); cycle(); bus_idle();
        for (int i = 0; i < 12; i++) begin
            bus_set(1, 0, 10, 0, 0); tstep(); cycle();
        end
        bus_idle();

        // match, interrupt, W1C and W1C coincident with a match
        op_wr(0, 32'h10000, 4'hF);
        op_wr(2, 32'd3, 4'hF);
        op_wr(0, 32'h10001, 4'hF);
        run(12);
        op_rd(1);
        op_wr(1, 32'h1, 4'h1);
        run_to(3);
        bus_set(0, 1, 1, 32'h1, 4'h1); tstep(); cycle(); bus_idle();
        op_rd(1);
        op_rd(1);

        // asynchronous reset with PWM high
        op_wr(2, 32'd8, 4'hF);
        op_wr(0, 32'h10001, 4'hF);
        run_to(2);
        run(1);
        check("pre_reset_pwm0", 32'(pwm[0]), 32'h1);
        #3 rst = 1;
        #1;
        check("async_rst_pwm", 32'(pwm), 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        check("async_rst_rdata", av.AV_ReadData, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        read_all();

`ifdef TIMER_PWM_CAPTURE_EN
        tv = 32'h1234;
        op_wr(0, 32'h0100_0001, 4'hF);
        cap_in = 1;
        for (int i = 0; i < 4; i++) begin
            thold(); cycle();
        end
        check("capture_value", m_cap, 32'h1234);
        op_rd(18);
        op_rd(1);
        op_wr(1, 32'h100, 4'h2);
        op_rd(1);
        cap_in = 0;
`endif

        // randomized traffic
        tper = $urandom_range(6, 30);
        tcnt = 0;
        for (int i = 0; i < 4000; i++) begin
            int r, a;
            logic [31:0] d;
            logic [3:0] be;
            if ($urandom_range(0, 9) < 7) tstep(); else thold();
            r  = $urandom_range(0, 99);
            a  = $urandom_range(0, 19);
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if (r < 35) begin
                bus_set(1, 0, a, 0, 0);
                av.AV_SlaveSel = ($urandom_range(0, 7) != 0);
            end else if (r < 55) begin
                d = $urandom;
                if (r < 40) begin
                    a = 0;
                    d[0] = ($urandom_range(0, 4) != 0);
                end else if (r < 52 && a >= 2 && a < 10) begin
                    d = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, tper + 2));
                end
                bus_set(0, 1, a, d, be);
            end else begin
                bus_idle();
            end
            if ($urandom_range(0, 15) == 0) cap_in = ~cap_in;
            cycle();
        end
        bus_idle();
        thold();
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
